// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: registered N-to-1 channel multiplexer with a valid/ready
// stream handshake. The channel comes from sel (DIRECT, mode=0) or from an
// internal wrapping scan counter (SCAN, mode=1). The output register holds
// its beat while out_ready is low.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   data_in           N_CH packed channels, channel k at [k*DATA_W +: DATA_W]
//   sel, mode         channel index (DIRECT) and mode select, sampled on accept
//   in_valid/in_ready request handshake; in_ready is combinational
//   out_data, out_ch  selected sample and its channel index
//   out_err           beat came from an out-of-range sel (>= N_CH)
//   out_last          SCAN beat from channel N_CH-1
//   out_valid/out_ready output beat handshake
//   out_par           ^out_data, present only when MUX_PARITY_EN is defined
//
// Optional feature macro: MUX_PARITY_EN
module mux_nto1_stream #(
   parameter int unsigned N_CH   = 16,
   parameter int unsigned DATA_W = 1,
   parameter int unsigned SEL_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*DATA_W-1:0]   data_in,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     mode,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_err,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready
`ifdef MUX_PARITY_EN
   ,
   output logic                     out_par
`endif
);

   // Parameter sanity checks at elaboration
   if (N_CH < 2) begin : g_bad_n_ch
      $error("mux_nto1_stream: N_CH must be >= 2");
   end
   if ((64'(1) << SEL_W) < 64'(N_CH)) begin : g_bad_sel_w
      $error("mux_nto1_stream: 2**SEL_W must be >= N_CH");
   end

   logic [SEL_W-1:0]  scan_cnt;
   logic [SEL_W-1:0]  ch_nxt;
   logic              err_nxt;
   logic              last_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              accept;

   // Output register can take a beat when empty or draining this cycle
   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Channel selection and beat payload for the next load
   always_comb begin
      ch_nxt   = mode ? scan_cnt : sel;
      err_nxt  = (32'(ch_nxt) >= N_CH);
      last_nxt = mode && (32'(ch_nxt) == N_CH - 1);
      // Out-of-range channels match no k and leave the zero default
      data_nxt = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         if (32'(ch_nxt) == k) begin
            data_nxt = data_in[k*DATA_W +: DATA_W];
         end
      end
   end

   // Output beat register; state is carried by out_valid (EMPTY/FULL)
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         out_err   <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= data_nxt;
         out_ch    <= ch_nxt;
         out_err   <= err_nxt;
         out_last  <= last_nxt;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Scan counter: pinned to 0 in DIRECT so SCAN always restarts at channel 0
   always_ff @(posedge clk) begin
      if (rst || !mode) begin
         scan_cnt <= '0;
      end else if (accept) begin
         scan_cnt <= (scan_cnt == SEL_W'(N_CH - 1)) ? '0 : scan_cnt + SEL_W'(1);
      end
   end

`ifdef MUX_PARITY_EN
   // Parity travels with the beat; zero data on out-of-range gives parity 0
   always_ff @(posedge clk) begin
      if (rst) begin
         out_par <= 1'b0;
      end else if (accept) begin
         out_par <= ^data_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Testbench for mux_nto1_stream: directed checks on a 16x1 instance and
// directed plus randomized checks on a 12x8 instance against a queue model.
module tb_mux_nto1_stream;

   localparam int unsigned NA = 16;
   localparam int unsigned NB = 12;
   localparam int unsigned WB = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: 16 channels x 1 bit
   logic [NA-1:0]    data_in_a;
   logic [3:0]       sel_a;
   logic             mode_a, in_valid_a, in_ready_a, out_ready_a;
   logic             out_data_a, out_err_a, out_last_a, out_valid_a;
   logic [3:0]       out_ch_a;
   // Instance B: 12 channels x 8 bits
   logic [NB*WB-1:0] data_in_b;
   logic [3:0]       sel_b;
   logic             mode_b, in_valid_b, in_ready_b, out_ready_b;
   logic [WB-1:0]    out_data_b;
   logic             out_err_b, out_last_b, out_valid_b;
   logic [3:0]       out_ch_b;
`ifdef MUX_PARITY_EN
   logic             out_par_a, out_par_b;
`endif

   mux_nto1_stream #(.N_CH(NA), .DATA_W(1), .SEL_W(4)) dut_a (
      .clk(clk), .rst(rst), .data_in(data_in_a), .sel(sel_a), .mode(mode_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .out_data(out_data_a),
      .out_ch(out_ch_a), .out_err(out_err_a), .out_last(out_last_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a)
`ifdef MUX_PARITY_EN
      , .out_par(out_par_a)
`endif
   );

   mux_nto1_stream #(.N_CH(NB), .DATA_W(WB), .SEL_W(4)) dut_b (
      .clk(clk), .rst(rst), .data_in(data_in_b), .sel(sel_b), .mode(mode_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
      .out_ch(out_ch_b), .out_err(out_err_b), .out_last(out_last_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b)
`ifdef MUX_PARITY_EN
      , .out_par(out_par_b)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference model for B: queue of pending beats plus the scan position
   typedef struct {
      logic [WB-1:0] data;
      logic [3:0]    ch;
      logic          err;
      logic          last;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned scan_idx = 0;

   task automatic model_edge();
      beat_t       b;
      int unsigned c;
      bit          acc;
      if (rst) begin
         exp_q.delete();
         scan_idx = 0;
      end else begin
         acc = in_valid_b && (exp_q.size() == 0 || out_ready_b);
         if (exp_q.size() != 0 && out_ready_b) void'(exp_q.pop_front());
         if (acc) begin
            c      = mode_b ? scan_idx : int'(sel_b);
            b.ch   = 4'(c);
            b.err  = (c >= NB);
            b.data = '0;
            if (!b.err) b.data = data_in_b[c*WB +: WB];
            b.last = mode_b && (c == NB - 1);
            exp_q.push_back(b);
         end
         if (!mode_b) scan_idx = 0;
         else if (acc) scan_idx = (scan_idx + 1) % NB;
      end
   endtask

   task automatic check_b();
      chk("b_valid", 32'(out_valid_b), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("b_data", 32'(out_data_b), 32'(exp_q[0].data));
         chk("b_ch",   32'(out_ch_b),   32'(exp_q[0].ch));
         chk("b_err",  32'(out_err_b),  32'(exp_q[0].err));
         chk("b_last", 32'(out_last_b), 32'(exp_q[0].last));
`ifdef MUX_PARITY_EN
         chk("b_par",  32'(out_par_b),  32'(^exp_q[0].data));
`endif
      end
   endtask

   task automatic check_b_ready();
      #1;
      chk("b_in_ready", 32'(in_ready_b), 32'(!rst && (exp_q.size() == 0 || out_ready_b)));
   endtask

   // One clock: model follows the edge, outputs sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_b();
   endtask

   task automatic chk_a(input string tag, input logic d, input logic [3:0] c, input logic l);
      chk({tag, "_valid"}, 32'(out_valid_a), 32'd1);
      chk({tag, "_data"},  32'(out_data_a),  32'(d));
      chk({tag, "_ch"},    32'(out_ch_a),    32'(c));
      chk({tag, "_err"},   32'(out_err_a),   32'd0);
      chk({tag, "_last"},  32'(out_last_a),  32'(l));
   endtask

   logic [15:0] pat = 16'hA5C3;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      data_in_a = pat; sel_a = '0; mode_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
      data_in_b = '0;  sel_b = '0; mode_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;

      // Reset held for two cycles
      tick();
      tick();
      chk("rst_valid", 32'(out_valid_a), 32'd0);
      chk("rst_data",  32'(out_data_a),  32'd0);
      chk("rst_ch",    32'(out_ch_a),    32'd0);
      chk("rst_err",   32'(out_err_a),   32'd0);
      chk("rst_last",  32'(out_last_a),  32'd0);
      chk("rst_rdy_a", 32'(in_ready_a),  32'd0);
      chk("rst_rdy_b", 32'(in_ready_b),  32'd0);
`ifdef MUX_PARITY_EN
      chk("rst_par",   32'(out_par_a),   32'd0);
`endif
      rst = 1'b0;
      #1;
      chk("rel_rdy_a", 32'(in_ready_a), 32'd1);

      // DIRECT back-to-back over all 16 channels
      in_valid_a = 1'b1;
      for (int s = 0; s < 16; s++) begin
         sel_a = 4'(s);
         tick();
         chk_a("direct", pat[s], 4'(s), 1'b0);
      end

      // SCAN for 20 beats, wraps after channel 15
      mode_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_a("scan", pat[i % 16], 4'(i % 16), (i % 16) == 15);
      end
      mode_a = 1'b0; sel_a = 4'd7;
      tick();
      chk_a("scan_dir", pat[7], 4'd7, 1'b0);
      mode_a = 1'b1;
      tick();
      chk_a("scan_restart", pat[0], 4'd0, 1'b0);

      // Backpressure: hold a beat for 5 cycles, then stream without loss
      mode_a = 1'b0; sel_a = 4'd3;
      tick();
      out_ready_a = 1'b0; sel_a = 4'd9;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_rdy0", 32'(in_ready_a), 32'd0);
         tick();
         chk_a("bp_hold", pat[3], 4'd3, 1'b0);
      end
      out_ready_a = 1'b1;
      for (int k = 9; k < 12; k++) begin
         sel_a = 4'(k);
         #1;
         chk("bp_rdy1", 32'(in_ready_a), 32'd1);
         tick();
         chk_a("bp_flow", pat[k], 4'(k), 1'b0);
      end
      in_valid_a = 1'b0;
      tick();
      chk("bp_drain", 32'(out_valid_a), 32'd0);

      // Out-of-range sel on the 12-channel instance, plus parity bytes
      data_in_b = {$urandom(), $urandom(), $urandom()};
      data_in_b[2*WB +: WB] = 8'h07;
      data_in_b[4*WB +: WB] = 8'h03;
      in_valid_b = 1'b1; sel_b = 4'd13;
      check_b_ready();
      tick();
      chk("oor_data", 32'(out_data_b), 32'd0);
      chk("oor_err",  32'(out_err_b),  32'd1);
      chk("oor_ch",   32'(out_ch_b),   32'd13);
`ifdef MUX_PARITY_EN
      chk("oor_par",  32'(out_par_b),  32'd0);
`endif
      sel_b = 4'd2;
      check_b_ready();
      tick();
      chk("ok_err",  32'(out_err_b),  32'd0);
      chk("ok_data", 32'(out_data_b), 32'h07);
`ifdef MUX_PARITY_EN
      chk("par_07",  32'(out_par_b),  32'd1);
`endif
      sel_b = 4'd4;
      check_b_ready();
      tick();
      chk("ok_data4", 32'(out_data_b), 32'h03);
`ifdef MUX_PARITY_EN
      chk("par_03",   32'(out_par_b),  32'd0);
`endif

      // Randomized traffic with mode flips, backpressure and occasional reset
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(59) == 0);
         in_valid_b  = ($urandom_range(3) != 0);
         out_ready_b = ($urandom_range(2) != 0);
         if ($urandom_range(15) == 0) mode_b = ~mode_b;
         sel_b     = 4'($urandom());
         data_in_b = {$urandom(), $urandom(), $urandom()};
         check_b_ready();
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
